// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit.
// A Moore FSM steps each instruction through FETCH/DECODE and an
// opcode-specific tail. Opcode and funct are decoded into datapath selects
// and an ALU operation. A memory-ready handshake stalls the FSM in the
// memory-access states (FETCH, MEMRD, MEMWR) until the access completes.
// The reset is synchronous and active-high. While it is asserted, every
// write strobe is held low, so an abandoned instruction cannot commit a
// partial register, memory or PC write.

module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalOp,
    output logic [3:0] State
);

    // State encodings; these values are visible on the State debug port.
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;

    // Supported opcodes.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes.
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control output codes.
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Internal ALU operation class chosen by the FSM.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] decode_state;
    logic       op_supported;

    // Raw Moore decode. The write strobes are gated by reset further down.
    logic       iord_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       pc_write_raw;
    logic       branch_raw;
    logic       reg_write_raw;
    logic       reg_dst_raw;
    logic       mem_to_reg_raw;
    logic       alu_src_a_raw;
    logic [1:0] alu_src_b_raw;
    logic [1:0] pc_src_raw;
    logic [1:0] alu_op;
    logic       illegal_raw;

    // Opcode legality check, used in DECODE to flag unsupported instructions.
    always_comb begin
        case (Op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
            default:                                       op_supported = 1'b0;
        endcase
    end

    // State register; reset forces FETCH at the next rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The memory states wait on MemReady, and all other
    // states ignore it. The unused encodings 12-15 recover to FETCH.
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH: begin
                if (MemReady) begin
                    next_state = DECODE;
                end else begin
                    next_state = FETCH;
                end
            end
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (Op == OP_LW) begin
                    next_state = MEMRD;
                end else begin
                    next_state = MEMWR;
                end
            end
            MEMRD: begin
                if (MemReady) begin
                    next_state = MEMWB;
                end else begin
                    next_state = MEMRD;
                end
            end
            MEMWB:   next_state = FETCH;
            MEMWR: begin
                if (MemReady) begin
                    next_state = FETCH;
                end else begin
                    next_state = MEMWR;
                end
            end
            EXECUTE: next_state = ALUWB;
            ALUWB:   next_state = FETCH;
            BRANCH:  next_state = FETCH;
            ADDIEX:  next_state = ADDIWB;
            ADDIWB:  next_state = FETCH;
            JUMP:    next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // While reset is asserted, the selects show FETCH values even if the
    // register still holds the abandoned state.
    assign decode_state = reset ? FETCH : state;

    // Moore control decode. Every output defaults to 0 (ALU operation add).
    // Each state then overrides only the signals it uses.
    always_comb begin
        iord_raw       = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        pc_write_raw   = 1'b0;
        branch_raw     = 1'b0;
        reg_write_raw  = 1'b0;
        reg_dst_raw    = 1'b0;
        mem_to_reg_raw = 1'b0;
        alu_src_a_raw  = 1'b0;
        alu_src_b_raw  = 2'b00;
        pc_src_raw     = 2'b00;
        alu_op         = ALUOP_ADD;
        illegal_raw    = 1'b0;
        case (decode_state)
            FETCH: begin
                alu_src_b_raw = 2'b01;
                ir_write_raw  = MemReady;
                pc_write_raw  = MemReady;
            end
            DECODE: begin
                alu_src_b_raw = 2'b11;
                illegal_raw   = ~op_supported;
            end
            MEMADR: begin
                alu_src_a_raw = 1'b1;
                alu_src_b_raw = 2'b10;
            end
            MEMRD: begin
                iord_raw = 1'b1;
            end
            MEMWB: begin
                mem_to_reg_raw = 1'b1;
                reg_write_raw  = 1'b1;
            end
            MEMWR: begin
                iord_raw      = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTE: begin
                alu_src_a_raw = 1'b1;
                alu_op        = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_dst_raw   = 1'b1;
                reg_write_raw = 1'b1;
            end
            BRANCH: begin
                alu_src_a_raw = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_src_raw    = 2'b01;
                branch_raw    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a_raw = 1'b1;
                alu_src_b_raw = 2'b10;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            JUMP: begin
                pc_src_raw   = 2'b10;
                pc_write_raw = 1'b1;
            end
            default: begin
                alu_op = ALUOP_ADD;
            end
        endcase
    end

    // ALU decoder. Unknown funct codes quietly fall back to add.
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default:   ALUControl = ALU_ADD;
        endcase
    end

    // Selects pass straight through.
    assign IorD     = iord_raw;
    assign RegDst   = reg_dst_raw;
    assign MemToReg = mem_to_reg_raw;
    assign ALUSrcA  = alu_src_a_raw;
    assign ALUSrcB  = alu_src_b_raw;
    assign PCSrc    = pc_src_raw;
    assign State    = state;

    // Strobes are suppressed during reset. The PC enable merges the
    // unconditional write with a taken branch.
    assign MemWrite  = mem_write_raw & ~reset;
    assign IRWrite   = ir_write_raw & ~reset;
    assign RegWrite  = reg_write_raw & ~reset;
    assign IllegalOp = illegal_raw & ~reset;
    assign PCEn      = (pc_write_raw | (branch_raw & Zero)) & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller.
// A sequence-level reference model tracks the list of steps for the current
// instruction and derives the expected outputs from a per-step table. The
// DUT is compared against this model on every cycle. Directed instructions
// also pin the model with literal state traces and control values.

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemWrite, IRWrite, PCEn, RegWrite, RegDst, MemToReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       IllegalOp;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    // Reference model: step list of the running instruction and position in it.
    int  seq[$];
    int  idx = 0;
    bit  model_valid = 1'b0;

    logic [19:0] obs_log [64];
    logic [5:0]  rnd_op;
    logic [5:0]  rnd_fn;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCEn       (PCEn),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .IllegalOp  (IllegalOp),
        .State      (State)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic bit op_legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) ||
               (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic int model_state();
        return seq[idx];
    endfunction

    // Expected output vector, packed as:
    // {State, IorD, MemWrite, IRWrite, PCEn, RegWrite, RegDst, MemToReg,
    //  ALUSrcA, ALUSrcB, PCSrc, ALUControl, IllegalOp}
    function automatic logic [19:0] expect_vec(input int st, input bit rst, input logic [5:0] op,
                                                input logic [5:0] fn, input bit z, input bit rdy);
        logic iord, mw, irw, pcen, rw, rd, m2r, srca, ill;
        logic [1:0] srcb, pcs;
        logic [2:0] alu;
        int eff;
        iord = 0; mw = 0; irw = 0; pcen = 0; rw = 0; rd = 0; m2r = 0; srca = 0; ill = 0;
        srcb = 2'b00; pcs = 2'b00; alu = 3'b010;
        eff = rst ? 0 : st;
        case (eff)
            0:  begin srcb = 2'b01; irw = rdy; pcen = rdy; end
            1:  begin srcb = 2'b11; ill = !op_legal(op); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin srca = 1; alu = funct_alu(fn); end
            7:  begin rd = 1; rw = 1; end
            8:  begin srca = 1; alu = 3'b110; pcs = 2'b01; pcen = z; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: begin rw = 1; end
            11: begin pcs = 2'b10; pcen = 1; end
            default: ;
        endcase
        if (rst) begin
            irw = 0; pcen = 0;
        end
        return {4'(st), iord, mw, irw, pcen, rw, rd, m2r, srca, srcb, pcs, alu, ill};
    endfunction

    task automatic start_path(input logic [5:0] op);
        case (op)
            6'h23:   seq = '{0, 1, 2, 3, 4};
            6'h2B:   seq = '{0, 1, 2, 5};
            6'h00:   seq = '{0, 1, 6, 7};
            6'h04:   seq = '{0, 1, 8};
            6'h08:   seq = '{0, 1, 9, 10};
            6'h02:   seq = '{0, 1, 11};
            default: seq = '{0, 1};
        endcase
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int st;
        if (reset) begin
            seq = '{0};
            idx = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            st = seq[idx];
            if (st == 0) begin
                if (MemReady) begin
                    start_path(Op);
                    idx = 1;
                end
            end else if (!((st == 3 || st == 5) && !MemReady)) begin
                idx++;
                if (idx >= seq.size()) begin
                    seq = '{0};
                    idx = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [5:0] op, input logic [5:0] fn,
                                 input bit z, input bit rdy);
        reset    = r;
        Op       = op;
        Funct    = fn;
        Zero     = z;
        MemReady = rdy;
    endtask

    task automatic checkOutput(output logic [19:0] obs);
        logic [19:0] exp;
        obs = {State, IorD, MemWrite, IRWrite, PCEn, RegWrite, RegDst, MemToReg,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, IllegalOp};
        if (model_valid) begin
            exp = expect_vec(model_state(), reset, Op, Funct, Zero, MemReady);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("[TB] FAIL cycle_outputs t=%0t actual=%05h expected=%05h (state exp %0d)",
                         $time, obs, exp, model_state());
            end
        end
    endtask

    task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One clock: drive at negedge, check shortly after, step the model, wait for the edge.
    task automatic run_cycle(input bit r, input logic [5:0] op, input logic [5:0] fn,
                             input bit z, input bit rdy, output logic [19:0] obs);
        @(negedge clk);
        applyStimulus(r, op, fn, z, rdy);
        #1;
        checkOutput(obs);
        model_step();
        @(posedge clk);
    endtask

    // Run one complete instruction from FETCH. Stall FETCH for fstall cycles
    // and the memory state for mstall cycles.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                            input int fstall, input int mstall,
                            output logic [63:0] trace, output int n);
        int fcnt, mcnt, st;
        bit left, rdy;
        logic [19:0] obs;
        fcnt = 0; mcnt = 0; left = 0; trace = '0; n = 0;
        while (1) begin
            st = model_state();
            if (st == 0) begin
                rdy = (fcnt >= fstall);
                fcnt++;
            end else if (st == 3 || st == 5) begin
                rdy = (mcnt >= mstall);
                mcnt++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            run_cycle(1'b0, op, fn, z, rdy, obs);
            obs_log[n] = obs;
            trace = {trace[59:0], obs[19:16]};
            n++;
            if (idx != 0) left = 1;
            if (left && idx == 0) break;
            if (n >= 60) begin
                total++;
                bad++;
                $display("[TB] FAIL instr_timeout actual=%0d cycles required<60", n);
                break;
            end
        end
    endtask

    initial begin
        logic [19:0] obs;
        logic [63:0] trace;
        int n;
        logic [5:0] fns [5];
        logic [2:0] alus [5];
        fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        alus = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        seq = '{0};

        // Power-up reset.
        run_cycle(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, obs);
        run_cycle(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, obs);
        check_lit("reset_state", 64'(obs[19:16]), 64'h0);

        // Reset held for two cycles in the middle of EXECUTE.
        run_cycle(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, obs);
        run_cycle(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, obs);
        run_cycle(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, obs);
        check_lit("rst_exec_state", 64'(obs[19:16]), 64'h6);
        check_lit("rst_exec_strobes", 64'({obs[14:11], obs[0]}), 64'h0);
        run_cycle(1'b1, 6'h00, 6'h20, 1'b0, 1'b1, obs);
        check_lit("rst_state_after_edge", 64'(obs[19:16]), 64'h0);
        check_lit("rst_strobes", 64'({obs[14:11], obs[0]}), 64'h0);
        run_cycle(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, obs);
        check_lit("post_rst_irwrite_pcen", 64'({obs[13], obs[12]}), 64'h3);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, obs);

        // R-type functions.
        for (int i = 0; i < 5; i++) begin
            do_instr(6'h00, fns[i], 1'b0, 0, 0, trace, n);
            check_lit("rtype_trace", trace, 64'h0167);
            check_lit("rtype_alu", 64'(obs_log[2][3:1]), 64'(alus[i]));
            check_lit("rtype_regwrite_dst", 64'({obs_log[2][11:10], obs_log[3][11:10]}), 64'h3);
        end

        // lw with a 3-cycle memory stall.
        do_instr(6'h23, 6'h00, 1'b0, 0, 3, trace, n);
        check_lit("lw_trace", trace, 64'h01233334);
        check_lit("lw_cycles", 64'(n), 64'd8);
        check_lit("lw_iord", 64'({obs_log[3][15], obs_log[4][15], obs_log[5][15], obs_log[6][15]}), 64'hF);
        check_lit("lw_wb", 64'({obs_log[7][11], obs_log[7][9]}), 64'h3);

        // sw with a 2-cycle fetch stall and a 1-cycle write stall.
        do_instr(6'h2B, 6'h00, 1'b0, 2, 1, trace, n);
        check_lit("sw_trace", trace, 64'h0001255);
        check_lit("sw_irwrite", 64'({obs_log[0][13], obs_log[1][13], obs_log[2][13]}), 64'h1);
        check_lit("sw_memwrite", 64'({obs_log[5][14], obs_log[6][14]}), 64'h3);

        // beq taken and not taken, then jump.
        do_instr(6'h04, 6'h00, 1'b1, 0, 0, trace, n);
        check_lit("beq_trace", trace, 64'h018);
        check_lit("beq_taken", 64'({obs_log[2][12], obs_log[2][5:4], obs_log[2][3:1]}), 64'b101110);
        do_instr(6'h04, 6'h00, 1'b0, 0, 0, trace, n);
        check_lit("beq_not_taken_pcen", 64'(obs_log[2][12]), 64'h0);
        do_instr(6'h02, 6'h00, 1'b0, 0, 0, trace, n);
        check_lit("j_trace", trace, 64'h01B);
        check_lit("j_cycles", 64'(n), 64'd3);
        check_lit("j_pc", 64'({obs_log[2][12], obs_log[2][5:4]}), 64'b110);

        // Illegal opcode, then addi.
        do_instr(6'h3F, 6'h00, 1'b0, 0, 0, trace, n);
        check_lit("illegal_trace", trace, 64'h01);
        check_lit("illegal_pulse", 64'({obs_log[0][0], obs_log[1][0]}), 64'h1);
        check_lit("illegal_strobes", 64'(obs_log[1][14:11]), 64'h0);
        do_instr(6'h08, 6'h00, 1'b0, 0, 0, trace, n);
        check_lit("addi_trace", trace, 64'h019A);
        check_lit("addi_ctrl", 64'({obs_log[2][7:6], obs_log[3][10], obs_log[3][11]}), 64'b1001);

        // Randomized traffic with occasional resets.
        rnd_op = 6'h00;
        rnd_fn = 6'h20;
        for (int c = 0; c < 3000; c++) begin
            bit r, z, rdy;
            int sel;
            r = ($urandom_range(0, 59) == 0);
            if (model_state() == 0) begin
                sel = $urandom_range(0, 7);
                case (sel)
                    0: rnd_op = 6'h00;
                    1: rnd_op = 6'h23;
                    2: rnd_op = 6'h2B;
                    3: rnd_op = 6'h04;
                    4: rnd_op = 6'h08;
                    5: rnd_op = 6'h02;
                    6: rnd_op = 6'h3F;
                    default: rnd_op = 6'($urandom);
                endcase
                sel = $urandom_range(0, 5);
                rnd_fn = (sel < 5) ? fns[sel] : 6'($urandom);
            end
            z   = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 3) != 0);
            run_cycle(r, rnd_op, rnd_fn, z, rdy, obs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle control unit for the MIPS core. It sequences one instruction over several clock cycles with a Moore FSM, and decodes opcode and funct into datapath selects and ALU operation. It drives the multicycle datapath: shared instruction/data memory, IR, A/B/ALUOut registers, and a PC with enable. A memory-ready handshake lets the FSM stall on slow memory.

## Interface
Parameters: none. Opcode and funct encodings are fixed by the MIPS ISA subset below.

Ports, clock and reset first:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- Op  in  6  Instr[31:26], valid from the IR after FETCH completes
- Funct  in  6  Instr[5:0]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- PCEn  out  1  PC load: PCWrite | (Branch & Zero)
- RegWrite  out  1  register file write
- RegDst  out  1  write register select: 0 = rt, 1 = rd
- MemToReg  out  1  writeback select: 0 = ALUOut, 1 = data register
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- IllegalOp  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- State  out  4  current state encoding, for debug and verification

## Operation
Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.

States and encodings, with transitions:
- FETCH (0)
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE (1)
  - ALUSrcA=0, ALUSrcB=11, ALUOp=add (precomputes the branch target).
  - Goes to MEMADR for lw/sw, EXECUTE for R-type, BRANCH for beq, ADDIEX for addi, JUMP for j.
  - Any other opcode: pulses IllegalOp and returns to FETCH.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD (3): IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB (4): RegDst=0, MemToReg=1, RegWrite=1. Goes to FETCH.
- MEMWR (5): IorD=1, MemWrite=1, held for the whole state. Leaves to FETCH on the cycle MemReady=1.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=funct. Goes to ALUWB.
- ALUWB (7): RegDst=1, MemToReg=0, RegWrite=1. Goes to FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, Branch=1. Goes to FETCH.
- ADDIEX (9): ALUSrcA=1, ALUSrcB=10, add. Goes to ADDIWB.
- ADDIWB (10): RegDst=0, MemToReg=0, RegWrite=1. Goes to FETCH.
- JUMP (11): PCSrc=10, PCWrite=1. Goes to FETCH.
- Encodings 12–15 are unreachable. If entered, go to FETCH with every write strobe at 0.

ALU decode:
- ALUOp=add gives 010; ALUOp=sub gives 110.
- ALUOp=funct maps 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
- Any other funct gives 010 (treated as add; not flagged).

Output defaults: any select not listed for a state is 0 (ALUControl defaults to 010). All strobes not listed for a state are 0.

## Timing
- Moore outputs are decoded from the state register.
  - Exception: IRWrite and PCEn are combinationally qualified by MemReady (FETCH) and Zero (BRANCH).
- Reset (synchronous):
  - While reset=1: the state register is loaded with FETCH at the next edge, and MemWrite, IRWrite, PCEn, RegWrite, IllegalOp are forced to 0.
  - Other outputs show FETCH values, and State reads 0 after the first reset edge.
  - Reset asserted mid-instruction abandons it; no partial register or memory write occurs in the reset cycle.
- Latency with MemReady tied to 1, in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. No strobe repeats on the completing cycle.
- MemReady is ignored in all other states.
- BRANCH with Zero=0: PCEn=0, and the PC keeps PC+4 written in FETCH.

## Test plan
- Reset: hold reset=1 for 2 cycles mid-EXECUTE → State=0 and all strobes 0 during reset. After release with MemReady=1: IRWrite=PCEn=1 in the first cycle.
- R-type add/sub/and/or/slt, MemReady=1 → states 0,1,6,7. ALUControl=010/110/000/001/111 in EXECUTE; RegWrite=1 and RegDst=1 only in ALUWB.
- lw with MemReady low for 3 cycles in MEMRD → 0,1,2,3,3,3,3,4 (8 cycles). IorD=1 throughout MEMRD; MemToReg=RegWrite=1 in MEMWB.
- sw with MemReady=0 for 2 FETCH cycles → IRWrite=0 while stalled. The sequence then runs through MEMWR (State=5), where MemWrite stays 1 until the MemReady=1 cycle, then the FSM returns to 0.
- beq with Zero=1, then Zero=0 → PCEn=1 (PCSrc=01, ALUControl=110) vs PCEn=0 in BRANCH. Also j → PCEn=1, PCSrc=10, 3 cycles total.
- Op=111111 → IllegalOp=1 for exactly one cycle in DECODE, no strobes, back to FETCH. addi → 0,1,9,10 with ALUSrcB=10 and RegDst=0.
